// File: rtl/sequence_evaluator.sv
// Scores streamed candidate sequences against a masked target and tracks the best one.
// Two-stage pipeline: registered score capture, then best-so-far update; the FSM drains it before reporting.
module sequence_evaluator #(
    parameter int SEQ_WIDTH   = 8,
    parameter int SCORE_WIDTH = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [SEQ_WIDTH-1:0]   i_target,
    input  logic [SEQ_WIDTH-1:0]   i_mask,
    input  logic [SEQ_WIDTH-1:0]   i_seq,
    input  logic                   i_valid,
    input  logic                   i_done,
    output logic                   o_ready,
    output logic [SEQ_WIDTH-1:0]   o_best_seq,
    output logic [SCORE_WIDTH-1:0] o_best_score,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_found,
    output logic                   o_result_valid
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t                 state;
    state_t                 state_next;

    logic [SEQ_WIDTH-1:0]   target;
    logic [SEQ_WIDTH-1:0]   mask;
    logic [SEQ_WIDTH-1:0]   seq_p1;
    logic [SCORE_WIDTH-1:0] score_p1;
    logic                   vld_p1;
    logic [SEQ_WIDTH-1:0]   best_seq_p2;
    logic [SCORE_WIDTH-1:0] best_score_p2;
    logic [COUNT_WIDTH-1:0] count;
    logic                   found;

    logic                   start;
    logic                   accept;
    logic                   perfect;
    logic [SCORE_WIDTH-1:0] score_c;
    logic [SCORE_WIDTH-1:0] mask_pop;

    function automatic logic [SCORE_WIDTH-1:0] popcount(input logic [SEQ_WIDTH-1:0] v);
        logic [SCORE_WIDTH-1:0] n;
        n = '0;
        for (int i = 0; i < SEQ_WIDTH; i++) begin
            n = n + SCORE_WIDTH'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    assign start    = i_start && (state == IDLE || state == DONE);
    assign accept   = i_valid && (state == RUN);
    assign score_c  = popcount(~(i_seq ^ target) & mask);
    assign mask_pop = popcount(mask);
    assign perfect  = accept && (score_c == mask_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = RUN;
            RUN:     if (perfect || i_done) state_next = FLUSH;
            // Stay until the last captured beat has reached the best-so-far registers.
            FLUSH:   if (!vld_p1) state_next = DONE;
            DONE:    if (i_start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // Stage 1: capture accepted beat and its score
    always_ff @(posedge clk) begin
        if (accept) begin
            seq_p1   <= i_seq;
            score_p1 <= score_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target        <= '0;
            mask          <= '0;
            vld_p1        <= 1'b0;
            best_seq_p2   <= '0;
            best_score_p2 <= '0;
            count         <= '0;
            found         <= 1'b0;
        end else if (start) begin
            target        <= i_target;
            mask          <= i_mask;
            vld_p1        <= 1'b0;
            best_seq_p2   <= '0;
            best_score_p2 <= '0;
            count         <= '0;
            found         <= 1'b0;
        end else begin
            vld_p1 <= accept;
            // Stage 2: strict compare so ties keep the earlier beat
            if (vld_p1 && (score_p1 > best_score_p2)) begin
                best_seq_p2   <= seq_p1;
                best_score_p2 <= score_p1;
            end
            if (accept) begin
                count <= sat_inc(count);
            end
            if (perfect) begin
                found <= 1'b1;
            end
        end
    end

    assign o_ready        = (state == RUN);
    assign o_result_valid = (state == DONE);
    assign o_best_seq     = best_seq_p2;
    assign o_best_score   = best_score_p2;
    assign o_count        = count;
    assign o_found        = found;

endmodule
